// File: rtl/traffic_light_controller.sv
// Two-street intersection sequencer: Moore FSM with min/max green dwell,
// fixed yellow and all-red clearance phases.
module traffic_light_controller #(
  parameter int MIN_GREEN      = 3,
  parameter int MAX_GREEN      = 8,
  parameter int YELLOW_CYCLES  = 2,
  parameter int ALL_RED_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [2:0] phase
);

  localparam int L0      = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
  localparam int L1      = (YELLOW_CYCLES > ALL_RED_CYCLES) ? YELLOW_CYCLES : ALL_RED_CYCLES;
  localparam int LARGEST = (L0 > L1) ? L0 : L1;
  localparam int CW      = (LARGEST > 1) ? $clog2(LARGEST) : 1;

  localparam logic [CW-1:0] MIN_END = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_END = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_END = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] RED_END = CW'(ALL_RED_CYCLES - 1);

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    RED_BA   = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          green_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= A_GREEN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt != MAX_END) cnt <= cnt + 1'b1;
    end
  end

  // Green ends once minimum dwell is met and the cross street waits, either
  // because the own street is empty or the maximum dwell has run out.
  always_comb begin
    green_done = 1'b0;
    if (cnt >= MIN_END) begin
      if (state == A_GREEN) green_done = tb && (!ta || cnt >= MAX_END);
      else                  green_done = ta && (!tb || cnt >= MAX_END);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      A_GREEN:  if (green_done)      state_next = A_YELLOW;
      A_YELLOW: if (cnt == YEL_END)  state_next = RED_AB;
      RED_AB:   if (cnt == RED_END)  state_next = B_GREEN;
      B_GREEN:  if (green_done)      state_next = B_YELLOW;
      B_YELLOW: if (cnt == YEL_END)  state_next = RED_BA;
      RED_BA:   if (cnt == RED_END)  state_next = A_GREEN;
      default:                       state_next = A_GREEN;
    endcase
  end

  always_comb begin
    la    = GREEN;
    lb    = RED;
    phase = state;
    case (state)
      A_GREEN:  begin la = GREEN;  lb = RED;    end
      A_YELLOW: begin la = YELLOW; lb = RED;    end
      RED_AB:   begin la = RED;    lb = RED;    end
      B_GREEN:  begin la = RED;    lb = GREEN;  end
      B_YELLOW: begin la = RED;    lb = YELLOW; end
      RED_BA:   begin la = RED;    lb = RED;    end
      default:  begin la = GREEN;  lb = RED;    end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller: directed scenarios plus
// randomized sensor traffic against a dwell-time reference model.
module tb_traffic_light_controller;

  localparam int MIN_G = 3;
  localparam int MAX_G = 8;
  localparam int YEL   = 2;
  localparam int RED   = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ta = 1'b0;
  logic       tb = 1'b0;
  logic [1:0] la, lb;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: current phase number and cycles spent in it
  int m_phase = 0;
  int m_dwell = 0;

  traffic_light_controller #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
    .YELLOW_CYCLES(YEL), .ALL_RED_CYCLES(RED)
  ) dut (
    .clock(clock), .reset(reset), .ta(ta), .tb(tb),
    .la(la), .lb(lb), .phase(phase)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] light_a(int p);
    return (p == 0) ? 2'b00 : (p == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] light_b(int p);
    return (p == 3) ? 2'b00 : (p == 4) ? 2'b01 : 2'b10;
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_dwell = 0;
  endfunction

  // Predicts the phase after the next edge from time-in-phase rules.
  function automatic void model_step(logic a, logic b);
    bit    go;
    logic  own, other;
    go = 1'b0;
    case (m_phase)
      0, 3: begin
        own   = (m_phase == 0) ? a : b;
        other = (m_phase == 0) ? b : a;
        go = (m_dwell + 1 >= MIN_G) && other && (!own || m_dwell + 1 >= MAX_G);
      end
      1, 4: go = (m_dwell + 1 == YEL);
      default: go = (m_dwell + 1 == RED);
    endcase
    if (go) begin
      m_phase = (m_phase + 1) % 6;
      m_dwell = 0;
    end else begin
      m_dwell++;
    end
  endfunction

  task automatic cycle(input logic a, input logic b);
    ta = a;
    tb = b;
    model_step(a, b);
    @(posedge clock);
    #1;
  endtask

  task automatic do_release();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ta = 1'b1;
    tb = 1'b1;
    #2;
    if (phase !== 3'd0 || la !== 2'b00 || lb !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_async: phase=%0d la=%b lb=%b, required phase=0 la=00 lb=10", phase, la, lb);
    end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      ta = 1'($urandom);
      tb = 1'($urandom);
      @(posedge clock);
      #1;
      if (phase !== 3'd0 || la !== 2'b00 || lb !== 2'b10) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: phase=%0d la=%b lb=%b, required phase=0 la=00 lb=10", i, phase, la, lb);
      end
      n_checks++;
    end
  endtask

  task automatic test_handover();
    int exp_ph[6] = '{0, 0, 1, 1, 2, 3};
    logic [1:0] exp_la[6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [1:0] exp_lb[6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    reset = 1'b1;
    ta = 1'b0;
    tb = 1'b1;
    do_release();
    for (int e = 0; e < 6; e++) begin
      cycle(1'b0, 1'b1);
      if (phase !== 3'(exp_ph[e]) || la !== exp_la[e] || lb !== exp_lb[e]) begin
        n_fail++;
        $display("FAIL handover edge %0d: phase=%0d la=%b lb=%b, required phase=%0d la=%b lb=%b",
                 e + 1, phase, la, lb, exp_ph[e], exp_la[e], exp_lb[e]);
      end
      n_checks++;
    end
  endtask

  task automatic test_fairness();
    int pat[$];
    reset = 1'b1;
    do_release();
    for (int i = 0; i < MAX_G; i++) pat.push_back(0);
    for (int i = 0; i < YEL; i++)   pat.push_back(1);
    for (int i = 0; i < RED; i++)   pat.push_back(2);
    for (int i = 0; i < MAX_G; i++) pat.push_back(3);
    for (int i = 0; i < YEL; i++)   pat.push_back(4);
    for (int i = 0; i < RED; i++)   pat.push_back(5);
    // pat[k] is the phase after edge k; index 0 is the cycle right after release
    for (int e = 1; e <= 2 * pat.size() + 2; e++) begin
      cycle(1'b1, 1'b1);
      if (phase !== 3'(pat[e % pat.size()])) begin
        n_fail++;
        $display("FAIL fairness edge %0d: phase=%0d, required %0d", e, phase, pat[e % pat.size()]);
      end
      n_checks++;
    end
  endtask

  task automatic test_idle();
    reset = 1'b1;
    do_release();
    for (int e = 1; e <= 20; e++) begin
      cycle(1'b0, 1'b0);
      if (phase !== 3'd0 || la !== 2'b00 || lb !== 2'b10) begin
        n_fail++;
        $display("FAIL idle edge %0d: phase=%0d la=%b lb=%b, required phase=0 la=00 lb=10", e, phase, la, lb);
      end
      n_checks++;
    end
  endtask

  task automatic test_short_request();
    reset = 1'b1;
    do_release();
    cycle(1'b0, 1'b1);
    for (int e = 2; e <= 20; e++) begin
      if (phase !== 3'd0) begin
        n_fail++;
        $display("FAIL short_request edge %0d: phase=%0d, required 0", e - 1, phase);
      end
      n_checks++;
      cycle(1'b0, 1'b0);
    end
  endtask

  task automatic test_committed_yellow_reset();
    reset = 1'b1;
    do_release();
    for (int e = 1; e <= 3; e++) cycle(1'b0, 1'b1);
    if (phase !== 3'd1) begin
      n_fail++;
      $display("FAIL yellow_entry: phase=%0d, required 1", phase);
    end
    n_checks++;
    cycle(1'b0, 1'b1);
    for (int e = 5; e <= 6; e++) cycle(1'b0, 1'b0);
    if (phase !== 3'd3 || lb !== 2'b00) begin
      n_fail++;
      $display("FAIL committed_yellow: phase=%0d lb=%b, required phase=3 lb=00", phase, lb);
    end
    n_checks++;
    #3;
    reset = 1'b1;
    #1;
    if (phase !== 3'd0 || la !== 2'b00 || lb !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_reset: phase=%0d la=%b lb=%b, required phase=0 la=00 lb=10", phase, la, lb);
    end
    n_checks++;
    do_release();
    cycle(1'b0, 1'b0);
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL after_mid_reset: phase=%0d, required 0", phase);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic a, b;
    a = 1'b0;
    b = 1'b0;
    reset = 1'b1;
    do_release();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) begin
        a = 1'($urandom);
        b = 1'($urandom);
      end
      if ($urandom_range(299) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        if (phase !== 3'd0 || la !== 2'b00 || lb !== 2'b10) begin
          n_fail++;
          $display("FAIL random_reset[%0d]: phase=%0d la=%b lb=%b, required phase=0 la=00 lb=10", i, phase, la, lb);
        end
        n_checks++;
        do_release();
      end
      cycle(a, b);
      if (phase !== 3'(m_phase) || la !== light_a(m_phase) || lb !== light_b(m_phase)) begin
        n_fail++;
        $display("FAIL random[%0d] ta=%b tb=%b: phase=%0d la=%b lb=%b, required phase=%0d la=%b lb=%b",
                 i, a, b, phase, la, lb, m_phase, light_a(m_phase), light_b(m_phase));
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_fairness();
    test_idle();
    test_short_request();
    test_committed_yellow_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
